// File: rtl/multi_word_add_seq.sv
// Word-serial W-bit adder: one shared 16-bit slice, one word per clock, LSW first.
// Optional subtract mode (A-B via inverted B and forced carry-in) when MWADD_SUB_EN is defined.
module multi_word_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                cin,
`ifdef MWADD_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic                busy
);

    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state;
    logic [15:0]   a_w   [WORDS];
    logic [15:0]   b_w   [WORDS];
    logic [15:0]   res_w [WORDS];
    logic          carry;
    logic [IW-1:0] idx;
`ifdef MWADD_SUB_EN
    logic          sub_q;
`endif

    logic [15:0] a_sl;
    logic [15:0] b_sl;
    logic [15:0] s_sl;
    logic        c_sl;

    // Shared 16-bit adder slice, fed by the word currently selected by idx.
    always_comb begin
        a_sl = a_w[idx];
`ifdef MWADD_SUB_EN
        b_sl = b_w[idx] ^ {16{sub_q}};
`else
        b_sl = b_w[idx];
`endif
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {16'd0, carry};
    end

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            result[16*i +: 16] = res_w[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
`ifdef MWADD_SUB_EN
            sub_q     <= 1'b0;
`endif
            for (int unsigned i = 0; i < WORDS; i++) begin
                a_w[i]   <= '0;
                b_w[i]   <= '0;
                res_w[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < WORDS; i++) begin
                            a_w[i] <= op_a[16*i +: 16];
                            b_w[i] <= op_b[16*i +: 16];
                        end
`ifdef MWADD_SUB_EN
                        sub_q <= sub;
                        carry <= sub | cin;
`else
                        carry <= cin;
`endif
                        idx      <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ADD: begin
                    res_w[idx] <= s_sl;
                    carry      <= c_sl;
                    if (idx == LAST) begin
                        // Slice is on the MSW here, so its msbs are the operand sign bits.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cout      <= c_sl;
                        ovf       <= (a_sl[15] == b_sl[15]) && (s_sl[15] != a_sl[15]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_word_add_seq.sv
// Self-checking bench for multi_word_add_seq (WORDS=4): directed literal cases plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_multi_word_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    int tests = 0;
    int fails = 0;

    multi_word_add_seq #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef MWADD_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Returns {ovf, cout, sum} of the full-width operation.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input logic s);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   t;
        logic         v;
        bb = s ? ~b : b;
        cc = s ? 1'b1 : c;
        t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        v  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return {v, t};
    endfunction

    // Transaction-level model: one request in flight, result due WORDS cycles after accept.
    logic         m_pending = 1'b0;
    int           cyc = 0;
    int           m_acc = 0;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (!m_pending) begin
                if (in_valid) begin
                    m_pending <= 1'b1;
                    m_acc     <= cyc + 1;
                    {m_ovf, m_cout, m_res} <= ref_op(op_a, op_b, cin, sub);
                end
            end else if ((cyc - m_acc >= WORDS) && out_ready) begin
                m_pending <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_ov;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_result", result, 0);
            chk("rst_cout", cout, 0);
            chk("rst_ovf", ovf, 0);
        end else begin
            exp_ov = m_pending && (cyc - m_acc >= WORDS);
            chk("in_ready", in_ready, !m_pending);
            chk("busy", busy, m_pending);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("result", result, m_res);
                chk("cout", cout, m_cout);
                chk("ovf", ovf, m_ovf);
            end
        end
    end

    // Directed op with literal expectations; DUT must be idle on entry.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int hold, input logic [W-1:0] er,
                         input logic eco, input logic eov, input string nm);
        int lat;
        @(posedge clk); #1;
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, WORDS);
        chk({nm, "_result"}, result, er);
        chk({nm, "_cout"}, cout, eco);
        chk({nm, "_ovf"}, ovf, eov);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            op_a = {$urandom, $urandom};
            @(posedge clk); #1;
            chk({nm, "_hold_result"}, result, er);
            chk({nm, "_hold_cout"}, cout, eco);
            chk({nm, "_hold_ovf"}, ovf, eov);
            chk({nm, "_hold_in_ready"}, in_ready, 0);
            chk({nm, "_hold_out_valid"}, out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        sub = 1'b0;
        chk({nm, "_post_in_ready"}, in_ready, 1);
        chk({nm, "_post_out_valid"}, out_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0,
              64'h0000_0000_0001_0000, 1'b0, 1'b0, "word_carry");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0,
              64'h0, 1'b1, 1'b0, "ripple_all");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 3,
              64'h8000_0000_0000_0000, 1'b0, 1'b1, "signed_ovf");

        // Abort an operation at idx=2.
        @(posedge clk); #1;
        op_a = 64'h1111_2222_3333_4444; op_b = 64'h5555_6666_7777_8888; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        @(posedge clk); #1 rst = 1'b0;
        do_op(64'h3, 64'h4, 1'b0, 1'b0, 0, 64'h7, 1'b0, 1'b0, "after_abort");

`ifdef MWADD_SUB_EN
        do_op(64'h5, 64'h7, 1'b1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
`endif

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst       = !rst && ($urandom_range(0, 255) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cin       = 1'($urandom);
            op_a      = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: op_b = ~op_a;
                1: begin op_a = '1; op_b = {$urandom_range(0, 1), 32'h0, 16'h0}; end
                2: op_b = {1'b0, op_a[W-2:0]};
                default: op_b = {$urandom, $urandom};
            endcase
`ifdef MWADD_SUB_EN
            sub = 1'($urandom);
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (WORDS + 3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
